neuron_mac: RTL and testbench
=============================

# neuron_mac

Serial multiply-accumulate neuron front end, directly upstream of the `sigmoid` stage in the XOR network datapath. It accepts one (activation, weight) term per handshake and accumulates the weighted sum in Q4.4. On the last term it adds the bias and clamps the result to the sigmoid's valid input range of ±4.0. The clamped 8-bit pre-activation is then presented on a valid/ready output that drives `sigmoid.x`.

## Interface
- `N_IN`, default 2: maximum number of terms per neuron evaluation (1..16).
- `ACC_W`, default 24: accumulator width, in signed Q(ACC_W-4).4 format.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  a term is present on the input.
- `in_ready`  out  1  the block accepts a term this cycle.
- `in_act`  in  16  activation, unsigned Q8.8 (256 = 1.0); either a sigmoid output or a primary input of 0 or 256.
- `in_weight`  in  8  weight, signed Q4.4.
- `in_last`  in  1  marks the final term of the current evaluation.
- `bias`  in  8  signed Q4.4; sampled on the cycle `in_last` is accepted.
- `out_valid`  out  1  a pre-activation is available.
- `out_ready`  in  1  the downstream stage takes the pre-activation.
- `out_x`  out  8  signed Q4.4, clamped to [-64, +64]; connects to `sigmoid.x`.
- `out_forced`  out  1  the evaluation was terminated by reaching the `N_IN` term count, without `in_last`.

## Operation
- A term is accepted when `in_valid && in_ready`.
- Product: compute `p = {1'b0,in_act} * in_weight` as a 25-bit signed value in Q12.12, then shift arithmetically right by 8 to get Q4.4.
  - Rounding is truncation toward -inf. Example: act=1, w=-1 gives -1.
- Accumulate: `acc <= acc + p`, with p sign-extended to `ACC_W`.
- Term counter `cnt` (width clog2(N_IN)+1) counts accepted terms.
- FSM states:
  - **S_ACC**: `in_ready=1`, `out_valid=0`.
    - Accept a non-final term: update `acc`, increment `cnt`.
    - Accept a final term (when `in_last=1` or `cnt==N_IN-1`):
      - Compute `s = acc + p + sext(bias)`.
      - Register `out_x = clamp(s, -64, +64)`.
      - Register `out_forced = ~in_last`.
      - Clear `acc` and `cnt`, then go to S_OUT.
  - **S_OUT**: `in_ready=0`, `out_valid=1`; `out_x` and `out_forced` are held stable.
    - When `out_ready=1`, go to S_ACC.
- Clamp rationale: the sigmoid approximation is valid only for |x| ≤ 4.0 (64 in Q4.4) and becomes non-monotonic beyond that. The clamp is therefore mandatory, not optional.
- Sizing: with act ≤ 0xFFFF and |w| ≤ 128, each |p| ≤ 32767. For N_IN ≤ 16, a 24-bit accumulator cannot overflow. No wrap detection is needed.

## Timing
- Reset values (when `rst_n=0` at a clock edge):
  - state = S_ACC; `acc=0`; `cnt=0`.
  - `out_valid=0`, `out_x=0`, `out_forced=0`.
  - `in_ready=1` from the first cycle after reset is released.
- Reset during a partial accumulation discards the partial sum. Reset during S_OUT drops the pending output.
- Latency: `out_valid` rises 1 cycle after the handshake that accepts the last term.
- Throughput: one evaluation every k+1 cycles for k terms, when `out_ready` is held high. Accepting the last term and the output handshake never overlap.
- `out_ready=1` in S_OUT gives `in_ready=1` on the next cycle.
- `in_valid=0` in S_ACC is a stall: `acc` and `cnt` hold.
- `in_ready` and `out_valid` are decoded from state only. There are no combinational paths from `in_valid` or `out_ready`.

## Structure
- Shared package `nn_pkg` holds:
  - `Q44_ONE=16`, `ACT_ONE=256`.
  - `SIG_X_MAX=64`, `SIG_X_MIN=-64`.
  - The width constants `ACT_W=16`, `W_W=8`.
  - The FSM state enum `mac_state_t`.
- One sub-module, `q44_clamp`: combinational saturation from `ACC_W` bits to 8-bit Q4.4 within [SIG_X_MIN, SIG_X_MAX]. It is reusable by later layers.

## Test plan
- After reset: `out_valid=0`, `in_ready=1`, `out_x=0`.
- Terms (256, 0x20) and (256, 0x20, last), bias -16 → `out_x=48` one cycle after the last handshake; `out_forced=0`.
- Terms (256, 0x7F) and (256, 0x7F, last), bias 0 → sum 254 clamps to `out_x=64`. Weights of -128 on both terms → `out_x=-64`.
- Term (1, 0xFF, last), bias 0 → `out_x=-1` (truncation toward -inf check).
- N_IN=2, two terms with `in_last=0` → output produced after the second term with `out_forced=1`.
- Hold `out_ready=0` for 5 cycles with `in_valid` high → `in_ready=0` and `out_x` stable throughout. Assert `rst_n=0` for one cycle in the middle of a second accumulation → the next evaluation starts from `acc=0`.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared constants and types for the XOR-network neuron datapath.
// Q4.4 values use 16 = 1.0; activations are unsigned Q8.8 with 256 = 1.0.
package nn_pkg;

  localparam int Q44_ONE   = 16;
  localparam int ACT_ONE   = 256;
  localparam int SIG_X_MAX = 64;
  localparam int SIG_X_MIN = -64;
  localparam int ACT_W     = 16;
  localparam int W_W       = 8;

  typedef enum logic {
    S_ACC = 1'b0,
    S_OUT = 1'b1
  } mac_state_t;

endpackage

// File: rtl/q44_clamp.sv
// Saturates a wide signed Q4.4 sum into the 8-bit range the sigmoid accepts.
module q44_clamp
  import nn_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic signed [ACC_W-1:0] s,
  output logic signed [W_W-1:0]   x
);

  localparam logic signed [ACC_W-1:0] HI = ACC_W'(SIG_X_MAX);
  localparam logic signed [ACC_W-1:0] LO = ACC_W'(SIG_X_MIN);

  always_comb begin
    x = s[W_W-1:0];
    if (s > HI) begin
      x = W_W'(SIG_X_MAX);
    end else if (s < LO) begin
      x = W_W'(SIG_X_MIN);
    end
  end

endmodule

// File: rtl/neuron_mac.sv
// Serial multiply-accumulate neuron front end feeding sigmoid.x.
// One (activation, weight) term per handshake; bias and clamp on the final term.
module neuron_mac
  import nn_pkg::*;
#(
  parameter int N_IN  = 2,
  parameter int ACC_W = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ACT_W-1:0]        in_act,
  input  logic signed [W_W-1:0]   in_weight,
  input  logic                    in_last,
  input  logic signed [W_W-1:0]   bias,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [W_W-1:0]   out_x,
  output logic                    out_forced
);

  localparam int CNT_W = $clog2(N_IN) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_IN - 1);

  // Q8.8 * Q4.4 = Q12.12; the arithmetic shift floors toward -inf.
  function automatic logic signed [ACC_W-1:0] scale_product(
    input logic [ACT_W-1:0]      act,
    input logic signed [W_W-1:0] w
  );
    logic signed [24:0] a_ext;
    logic signed [24:0] w_ext;
    logic signed [24:0] full;
    a_ext = {9'b0, act};
    w_ext = {{17{w[W_W-1]}}, w};
    full  = a_ext * w_ext;
    return ACC_W'(full >>> 8);
  endfunction

  mac_state_t                state;
  logic signed [ACC_W-1:0]   acc_p1;
  logic [CNT_W-1:0]          cnt_p1;
  logic signed [ACC_W-1:0]   prod_p0;
  logic signed [ACC_W-1:0]   sum_p0;
  logic signed [W_W-1:0]     x_clamped_p0;
  logic                      is_final_p0;

  // Stage p0: product, biased sum and final-term decode for the presented term
  always_comb begin
    prod_p0     = scale_product(in_act, in_weight);
    sum_p0      = acc_p1 + prod_p0 + ACC_W'(bias);
    is_final_p0 = in_last || (cnt_p1 == CNT_LAST);
  end

  q44_clamp #(
    .ACC_W (ACC_W)
  ) u_clamp (
    .s (sum_p0),
    .x (x_clamped_p0)
  );

  // Stage p1: accumulator, term counter and held output
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_ACC;
      acc_p1     <= '0;
      cnt_p1     <= '0;
      out_x      <= '0;
      out_forced <= 1'b0;
    end else begin
      case (state)
        S_ACC: begin
          if (in_valid) begin
            if (is_final_p0) begin
              out_x      <= x_clamped_p0;
              out_forced <= ~in_last;
              acc_p1     <= '0;
              cnt_p1     <= '0;
              state      <= S_OUT;
            end else begin
              acc_p1 <= acc_p1 + prod_p0;
              cnt_p1 <= cnt_p1 + 1'b1;
            end
          end
        end
        S_OUT: begin
          if (out_ready) begin
            state <= S_ACC;
          end
        end
        default: state <= S_ACC;
      endcase
    end
  end

  assign in_ready  = (state == S_ACC);
  assign out_valid = (state == S_OUT);

endmodule

// File: tb/tb_neuron_mac.sv
// Bench for neuron_mac: table of evaluations checked through an output scoreboard,
// plus hand-written back-pressure and reset sequences.
module tb_neuron_mac;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       in_act;
  logic signed [7:0] in_weight;
  logic              in_last;
  logic signed [7:0] bias;
  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] out_x;
  logic              out_forced;

  neuron_mac #(.N_IN(2), .ACC_W(24)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_act     (in_act),
    .in_weight  (in_weight),
    .in_last    (in_last),
    .bias       (bias),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_x      (out_x),
    .out_forced (out_forced)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]       a0;
    logic signed [7:0] w0;
    logic              l0;
    logic [15:0]       a1;
    logic signed [7:0] w1;
    logic              l1;
    int                nt;
    logic signed [7:0] b;
    int                exp_x;
    logic              exp_f;
  } vec_t;

  typedef struct {
    int   x;
    logic f;
  } exp_t;

  vec_t vecs[10];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Output side of the scoreboard
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_x", int'(out_x), e.x);
        check("out_forced", int'(out_forced), int'(e.f));
      end
    end
  end

  task automatic put_term(input logic [15:0] a, input logic signed [7:0] w,
                          input logic last, input logic signed [7:0] b,
                          input logic final_term, input int ex, input logic ef);
    int guard;
    @(negedge clk);
    in_valid  = 1'b1;
    in_act    = a;
    in_weight = w;
    in_last   = last;
    bias      = b;
    guard     = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    if (final_term) begin
      exp_t e;
      e.x = ex;
      e.f = ef;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (final_term) check("latency_out_valid", int'(out_valid), 1);
  endtask

  task automatic run_vec(input vec_t v);
    put_term(v.a0, v.w0, v.l0, v.b, v.nt == 1, v.exp_x, v.exp_f);
    if (v.nt == 2) put_term(v.a1, v.w1, v.l1, v.b, 1'b1, v.exp_x, v.exp_f);
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while ((sb.size() != 0 || out_valid) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1);
  end

  initial begin
    logic signed [7:0] held;
    vecs[0] = '{16'd256, 8'sh20, 1'b0, 16'd256, 8'sh20, 1'b1, 2, -8'sd16, 48, 1'b0};
    vecs[1] = '{16'd256, 8'sh7F, 1'b0, 16'd256, 8'sh7F, 1'b1, 2, 8'sd0, 64, 1'b0};
    vecs[2] = '{16'd256, -8'sd128, 1'b0, 16'd256, -8'sd128, 1'b1, 2, 8'sd0, -64, 1'b0};
    vecs[3] = '{16'd1, -8'sd1, 1'b1, 16'd0, 8'sd0, 1'b0, 1, 8'sd0, -1, 1'b0};
    vecs[4] = '{16'd256, 8'sh10, 1'b0, 16'd256, 8'sh10, 1'b0, 2, 8'sd5, 37, 1'b1};
    vecs[5] = '{16'd128, 8'sh10, 1'b0, 16'd384, 8'sh08, 1'b1, 2, 8'sd0, 20, 1'b0};
    vecs[6] = '{16'hFFFF, -8'sd128, 1'b0, 16'hFFFF, 8'sh7F, 1'b1, 2, 8'sd127, -64, 1'b0};
    vecs[7] = '{16'd3, -8'sd1, 1'b1, 16'd0, 8'sd0, 1'b0, 1, 8'sd1, 0, 1'b0};
    vecs[8] = '{16'd256, 8'sh20, 1'b0, 16'd256, 8'sh20, 1'b1, 2, 8'sd0, 64, 1'b0};
    vecs[9] = '{16'd256, -8'sd32, 1'b0, 16'd256, -8'sd32, 1'b1, 2, -8'sd1, -64, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; in_act = '0; in_weight = '0;
    in_last = 1'b0; bias = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_out_x", int'(out_x), 0);
    check("reset_out_forced", int'(out_forced), 0);

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i]);
      wait_drain();
    end

    // Back-pressure: output must hold while in_valid stays high
    out_ready = 1'b0;
    run_vec(vecs[0]);
    in_valid = 1'b1; in_act = 16'd256; in_weight = 8'sh40; in_last = 1'b1;
    held = out_x;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("hold_in_ready", int'(in_ready), 0);
      check("hold_out_valid", int'(out_valid), 1);
      check("hold_out_x", int'(out_x), int'(held));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("ready_after_out", int'(in_ready), 1);
    wait_drain();

    // Reset in the middle of an accumulation discards the partial sum
    put_term(16'd256, 8'sh40, 1'b0, 8'sd0, 1'b0, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    put_term(16'd256, 8'sh10, 1'b1, 8'sd0, 1'b1, 16, 1'b0);
    wait_drain();

    // Reset while an output is pending drops it
    out_ready = 1'b0;
    run_vec(vecs[5]);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    void'(sb.pop_front());
    check("rst_drop_out_valid", int'(out_valid), 0);
    check("rst_drop_out_x", int'(out_x), 0);
    check("rst_drop_in_ready", int'(in_ready), 1);
    out_ready = 1'b1;
    run_vec(vecs[4]);
    wait_drain();

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
